// File: rtl/pport_pkg.sv
// pport_pkg: shared state type, direction constants and default widths for the parallel-port host
package pport_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_TURN, ST_SETUP, ST_STROBE, ST_WAITFB, ST_DONE} pp_state_t;
  localparam logic PP_DIR_WR = 1'b1;
  localparam logic PP_DIR_RD = 1'b0;
  localparam int PP_DW = 8;
  localparam int PP_CW = 10;
  localparam int PP_TURNAROUND = 4;
  localparam int PP_SETUP = 2;
  localparam int PP_NSYNC = 2;
  localparam int PP_TIMEOUT = 1023;
endpackage

// File: rtl/pport_sync.sv
// pport_sync: N-deep, W-wide flop synchronizer with synchronous reset to zero
module pport_sync import pport_pkg::*; #(
  parameter int W = 1,
  parameter int N = PP_NSYNC
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [N*W-1:0]     r_sr;
  logic [(N+1)*W-1:0] w_sh;
  assign w_sh = {r_sr, i_d};
  assign o_q  = r_sr[N*W-1 -: W];
  always_ff @(posedge i_clk)
    r_sr <= i_reset ? '0 : w_sh[N*W-1:0];
endmodule

// File: rtl/pport_host.sv
// pport_host: host-side initiator for the 8-bit parallel-port link, paced by the device clkfb echo
module pport_host import pport_pkg::*; #(
  parameter int TURNAROUND = PP_TURNAROUND,
  parameter int SETUP      = PP_SETUP,
  parameter int NSYNC      = PP_NSYNC,
  parameter int TIMEOUT    = PP_TIMEOUT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_stb,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_req,
  output logic       o_busy,
  output logic       o_rd_stb,
  output logic [7:0] o_rd_data,
  output logic       o_err,
  output logic       o_pp_dir,
  output logic       o_pp_clk,
  output logic [7:0] o_pp_data,
  input  logic [7:0] i_pp_data,
  input  logic       i_pp_clkfb
);
  pp_state_t        r_state, w_state;
  logic [PP_CW-1:0] r_cnt, w_cnt, w_inc;
  logic             r_is_rd, w_is_rd;
  logic             w_fb_s, w_dir, w_clk, w_rd_stb, w_err;
  logic [7:0]       w_d_s, w_data, w_rd_data;
  logic             w_turn_done, w_setup_done, w_tmo;

  pport_sync #(.W(1), .N(NSYNC)) u_sync_fb (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_pp_clkfb), .o_q(w_fb_s)
  );
  pport_sync #(.W(PP_DW), .N(NSYNC)) u_sync_data (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_pp_data), .o_q(w_d_s)
  );

  assign o_busy       = r_state != ST_IDLE;
  assign w_inc        = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_turn_done  = 32'(w_inc) >= TURNAROUND;
  assign w_setup_done = 32'(w_inc) >= SETUP;
  assign w_tmo        = 32'(w_inc) >= TIMEOUT;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_is_rd   = r_is_rd;
    w_dir     = o_pp_dir;
    w_clk     = o_pp_clk;
    w_data    = o_pp_data;
    w_rd_data = o_rd_data;
    w_rd_stb  = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_stb) begin
          w_data  = i_wr_data;
          w_is_rd = 1'b0;
          w_cnt   = '0;
          w_dir   = PP_DIR_WR;
          w_state = (o_pp_dir == PP_DIR_WR) ? ST_SETUP : ST_TURN;
        end else if (i_rd_req) begin
          w_is_rd = 1'b1;
          w_cnt   = '0;
          w_dir   = PP_DIR_RD;
          w_state = (o_pp_dir == PP_DIR_RD) ? ST_STROBE : ST_TURN;
        end
      end
      ST_TURN: begin
        w_cnt   = w_turn_done ? '0 : w_inc;
        w_state = w_turn_done ? (r_is_rd ? ST_STROBE : ST_SETUP) : ST_TURN;
      end
      ST_SETUP: begin
        w_cnt   = w_setup_done ? '0 : w_inc;
        w_state = w_setup_done ? ST_STROBE : ST_SETUP;
      end
      ST_STROBE: begin
        w_clk   = ~o_pp_clk;
        w_cnt   = '0;
        w_state = ST_WAITFB;
      end
      ST_WAITFB: begin
        if (w_fb_s == o_pp_clk) begin
          w_state = ST_DONE;
        end else if (w_tmo) begin
          w_err   = 1'b1;
          w_clk   = w_fb_s;
          w_state = ST_IDLE;
        end else begin
          w_cnt = w_inc;
        end
      end
      ST_DONE: begin
        w_rd_stb  = r_is_rd;
        w_rd_data = r_is_rd ? w_d_s : o_rd_data;
        w_state   = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_rd   <= 1'b0;
      o_pp_dir  <= PP_DIR_WR;
      o_pp_clk  <= 1'b0;
      o_pp_data <= '0;
      o_rd_data <= '0;
      o_rd_stb  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_is_rd   <= w_is_rd;
      o_pp_dir  <= w_dir;
      o_pp_clk  <= w_clk;
      o_pp_data <= w_data;
      o_rd_data <= w_rd_data;
      o_rd_stb  <= w_rd_stb;
      o_err     <= w_err;
    end
  end
endmodule

// File: tb/tb_pport_host.sv
// tb_pport_host: table-driven bench for pport_host with a clkfb-echoing device model
module tb_pport_host;
  logic       clk = 1'b0, rst = 1'b1, wr_stb = 1'b0, rd_req = 1'b0, pp_clkfb = 1'b0;
  logic [7:0] wr_data = '0, pp_din = '0;
  logic       busy, rd_stb, err, pp_dir, pp_clk;
  logic [7:0] rd_data, pp_dout;
  int         n_pass = 0, n_tot = 0;
  logic       dev_en = 1'b1, dev_last = 1'b0, dev_pend = 1'b0;
  int         dev_delay = 3, dev_cnt = 0;
  logic [7:0] dev_byte = '0;
  int         stb_seen = 0, err_seen = 0;

  always #5 clk = ~clk;

  pport_host dut (
    .i_clk(clk), .i_reset(rst), .i_wr_stb(wr_stb), .i_wr_data(wr_data), .i_rd_req(rd_req),
    .o_busy(busy), .o_rd_stb(rd_stb), .o_rd_data(rd_data), .o_err(err),
    .o_pp_dir(pp_dir), .o_pp_clk(pp_clk), .o_pp_data(pp_dout),
    .i_pp_data(pp_din), .i_pp_clkfb(pp_clkfb)
  );

  always @(negedge clk) begin
    if (rst) begin
      dev_last = 1'b0;
      dev_pend = 1'b0;
      pp_clkfb = 1'b0;
    end else if (pp_clk != dev_last) begin
      dev_last = pp_clk;
      if (!pp_dir) pp_din = dev_byte;
      dev_cnt  = dev_delay;
      dev_pend = 1'b1;
    end else if (dev_pend && dev_en) begin
      if (dev_cnt <= 1) begin
        pp_clkfb = dev_last;
        dev_pend = 1'b0;
      end else dev_cnt--;
    end
  end

  always @(negedge clk) begin
    if (rd_stb) stb_seen++;
    if (err) err_seen++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] wd;
    logic [7:0] dev;
    int         lat;
    int         done;
    logic       dir;
    logic       clk;
    logic       stb;
    logic [7:0] rdd;
  } vec_t;

  task automatic txn(input logic [1:0] op, input logic [7:0] wd, output int lat, output int done,
                     output int stable, output int stb_n, output logic [7:0] rdd,
                     output int err_n, output logic dir_t, output logic [7:0] data_t);
    logic c0;
    @(negedge clk);
    c0 = pp_clk;
    wr_stb = op != 2'd1;
    rd_req = op != 2'd0;
    wr_data = wd;
    @(negedge clk);
    wr_stb = 1'b0;
    rd_req = 1'b0;
    lat = -1; done = -1; stable = 0; stb_n = 0; err_n = 0; rdd = '0; dir_t = 1'b0; data_t = '0;
    for (int c = 1; c <= 2000 && done < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (lat < 0 && pp_clk != c0) begin
        lat = c;
        dir_t = pp_dir;
        data_t = pp_dout;
      end else if (lat < 0) stable = (pp_dout == wd) ? stable + 1 : 0;
      if (rd_stb) begin
        stb_n++;
        rdd = rd_data;
      end
      if (err) err_n++;
      if (!busy) done = c;
    end
    @(negedge clk);
    if (rd_stb) stb_n++;
    if (err) err_n++;
  endtask

  initial begin
    vec_t v[8];
    int lat, done, stable, stb_n, err_n, k;
    logic [7:0] rdd, data_t;
    logic dir_t;
    v[0] = '{2'd0, 8'hA5, 8'h00, 4, 11, 1'b1, 1'b1, 1'b0, 8'h00};
    v[1] = '{2'd0, 8'h0D, 8'h00, 4, 11, 1'b1, 1'b0, 1'b0, 8'h00};
    v[2] = '{2'd1, 8'h00, 8'h3C, 6, 13, 1'b0, 1'b1, 1'b1, 8'h3C};
    v[3] = '{2'd1, 8'h00, 8'h01, 2,  9, 1'b0, 1'b0, 1'b1, 8'h01};
    v[4] = '{2'd1, 8'h00, 8'h02, 2,  9, 1'b0, 1'b1, 1'b1, 8'h02};
    v[5] = '{2'd1, 8'h00, 8'h03, 2,  9, 1'b0, 1'b0, 1'b1, 8'h03};
    v[6] = '{2'd2, 8'h55, 8'hEE, 8, 15, 1'b1, 1'b1, 1'b0, 8'h00};
    v[7] = '{2'd0, 8'h81, 8'h00, 4, 11, 1'b1, 1'b0, 1'b0, 8'h00};

    repeat (3) @(negedge clk);
    chk("reset dir", pp_dir, 1);
    chk("reset clk", pp_clk, 0);
    chk("reset data", pp_dout, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_stb", rd_stb, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      dev_byte = v[i].dev;
      txn(v[i].op, v[i].wd, lat, done, stable, stb_n, rdd, err_n, dir_t, data_t);
      chk($sformatf("v%0d strobe latency", i), lat, v[i].lat);
      chk($sformatf("v%0d done cycle", i), done, v[i].done);
      chk($sformatf("v%0d dir at strobe", i), dir_t, v[i].dir);
      chk($sformatf("v%0d dir after", i), pp_dir, v[i].dir);
      chk($sformatf("v%0d clk after", i), pp_clk, v[i].clk);
      chk($sformatf("v%0d rd_stb count", i), stb_n, 32'(v[i].stb));
      chk($sformatf("v%0d err count", i), err_n, 0);
      if (v[i].stb) chk($sformatf("v%0d rd_data", i), rdd, v[i].rdd);
      if (v[i].op != 2'd1) begin
        chk($sformatf("v%0d data at strobe", i), data_t, v[i].wd);
        chk($sformatf("v%0d setup held", i), stable >= 2, 1);
      end
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dev_en = 1'b0;
    stb_seen = 0;
    err_seen = 0;
    wr_stb = 1'b1;
    wr_data = 8'hE7;
    @(negedge clk);
    wr_stb = 1'b0;
    for (k = 0; k < 20 && pp_clk == 1'b0; k++) @(negedge clk);
    chk("timeout strobe seen", pp_clk, 1);
    for (k = 0; k < 1100 && !err; ) begin
      @(negedge clk);
      k++;
    end
    chk("timeout cycles", k, 1023);
    chk("timeout clk = fb", pp_clk, 0);
    chk("timeout busy", busy, 0);
    @(negedge clk);
    chk("timeout err width", err, 0);
    chk("timeout err count", err_seen, 1);
    chk("timeout no rd_stb", stb_seen, 0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dev_en = 1'b1;
    dev_delay = 20;
    dev_byte = 8'h99;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (k = 0; k < 20 && pp_clk == 1'b0; k++) @(negedge clk);
    chk("rst-wait strobe seen", pp_clk, 1);
    repeat (3) @(negedge clk);
    chk("rst-wait busy before", busy, 1);
    rst = 1'b1;
    stb_seen = 0;
    err_seen = 0;
    @(negedge clk);
    chk("rst-wait dir", pp_dir, 1);
    chk("rst-wait clk", pp_clk, 0);
    chk("rst-wait busy", busy, 0);
    chk("rst-wait rd_data", rd_data, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst-wait no rd_stb", stb_seen, 0);
    chk("rst-wait no err", err_seen, 0);
    chk("rst-wait idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
